xalu_serial: RTL and testbench
==============================

XALU_SERIAL -- requirements
Module: xalu_serial

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the operand/result width; it SHALL be a multiple of 4 and at least 4.
REQ-002 The module SHALL define the derived constant N = WIDTH/4, the number of 4-bit slices processed per operation.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): the operation-request handshake.
REQ-006 The module SHALL have ports a and b, both input, WIDTH bits: operands A and B.
REQ-007 The module SHALL have port func, input, 3 bits: the function code.
REQ-008 The module SHALL have port com, input, 1 bit: complement-output mode.
REQ-009 The module SHALL have ports ci_left and ci_right, both input, 1 bit: the left and right carry/shift-in bits.
REQ-010 The module SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): the result handshake.
REQ-011 The module SHALL have port result, output, WIDTH bits: the operation result.
REQ-012 The module SHALL have ports co_left and co_right, both output, 1 bit: the left and right carry-out bits.
REQ-013 The module SHALL have port equ, output, 1 bit: high when a == b.
REQ-014 The module SHALL have ports zero and neg_zero, both output, 1 bit: high when result is all zeros (zero) or all ones (neg_zero).

Function
REQ-015 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-017 In IDLE with in_valid=1, the block SHALL capture a, b, func, com, ci_left and ci_right, clear the slice index, load the carry register with ci_right, and go to RUN.
REQ-018 In RUN, the block SHALL process one slice per cycle, LSB-first: slice k covers bits 4k+3..4k.
REQ-019 In RUN, the block SHALL write slice k into the result register, update the carry register, and increment k.
REQ-020 After slice N-1 the block SHALL go to DONE, so out_valid rises exactly N cycles after the accepting edge.
REQ-021 Inputs SHALL be ignored outside the accept cycle; the block SHALL use only the captured copies.
REQ-022 DONE SHALL hold result and all flags stable until out_ready=1, then go to IDLE; in_valid in DONE SHALL be ignored.
REQ-023 func 0, ADD: result = (A+B+ci_right) mod 2^WIDTH, with the carry rippling slice to slice through the carry register; co_left = carry out of bit WIDTH-1.
REQ-024 func 1, 2, 3: result = A&B, A|B, A^B respectively (bitwise).
REQ-025 func 4 and 5: result = A (PASSA) and B (PASSB) respectively.
REQ-026 func 6, SHR: result = {ci_left, A[WIDTH-1:1]}; co_right = A[0].
REQ-027 func 7, SHL: result = {A[WIDTH-2:0], ci_right}; co_left = A[WIDTH-1].
REQ-028 Each slice SHALL read the neighbouring bits it needs for SHR/SHL directly from the captured operand, with no extra cycles.
REQ-029 co_left SHALL be 0 except for ADD and SHL; co_right SHALL be 0 except for SHR.
REQ-030 com=1 SHALL invert every result bit after the function is applied; the carry outputs SHALL NOT be inverted.
REQ-031 zero and neg_zero SHALL be evaluated on the final (post-com) result.
REQ-032 equ SHALL equal (A == B) on the captured operands, independent of func and com, accumulated per slice.
REQ-033 The minimum issue interval SHALL be N+2 cycles; back-to-back operations without an IDLE cycle are not supported.

Reset
REQ-034 rst_n low SHALL immediately force IDLE and clear result, co_left, co_right, equ, zero, neg_zero, out_valid, the slice index and the carry register to 0.
REQ-035 in_ready SHALL be 1 while in IDLE after reset.
REQ-036 Reset during RUN or DONE SHALL abort the operation, with no partial result visible afterward.
REQ-037 The first operation after reset release SHALL complete normally.

Verification (WIDTH=16 unless stated)
REQ-038 The bench SHALL cover ADD a=0xFFFF, b=0x0001, ci_right=0 -> result=0x0000, co_left=1, zero=1, equ=0, with out_valid exactly 4 cycles after accept.
REQ-039 The bench SHALL cover SHR a=0x8001, ci_left=1 -> result=0xC000, co_right=1, co_left=0; and SHL a=0x8001, ci_right=1 -> result=0x0003, co_left=1.
REQ-040 The bench SHALL cover XOR a=b=0x1234, com=1 -> result=0xFFFF, neg_zero=1, zero=0, equ=1.
REQ-041 The bench SHALL cover backpressure: out_ready held 0 for 10 cycles in DONE -> result/flags unchanged, in_ready=0, a pulsed in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-042 The bench SHALL cover reset asserted after 2 RUN cycles -> all outputs 0 asynchronously, in_ready=1 after release; a following ADD 0x00FF+0x0001 -> result=0x0100.
REQ-043 The bench SHALL cover a WIDTH=4 instance, ADD a=0x9, b=0x8, ci_right=1 -> result=0x2, co_left=1, out_valid 1 cycle after accept.

Source files
------------

// File: rtl/xalu_serial.sv
// Nibble-serial ALU: one operation is accepted in IDLE, processed one 4-bit slice per
// cycle (LSB first) in RUN, and held in DONE until the consumer takes it.
module xalu_serial #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       func,
   input  logic             com,
   input  logic             ci_left,
   input  logic             ci_right,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             co_left,
   output logic             co_right,
   output logic             equ,
   output logic             zero,
   output logic             neg_zero
);
   localparam int N  = WIDTH / 4;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0]    LAST    = KW'(N - 1);
   localparam logic [WIDTH-1:0] SL_MASK = WIDTH'(4'hF);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;

   logic [WIDTH-1:0] a_cap, b_cap;
   logic [2:0]       func_cap;
   logic             com_cap, cil_cap, cir_cap;
   logic [KW-1:0]    k;
   logic             carry, eq_acc, zero_acc, ones_acc;

   logic             accept, step, last;
   logic [KW+1:0]    bit_ofs;
   logic [WIDTH-1:0] shr_word, shl_word;
   logic [3:0]       a_sl, b_sl, fn_sl, res_sl;
   logic [4:0]       sum_sl;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (k == LAST) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   assign accept   = (state == IDLE) && in_valid;
   assign step     = (state == RUN);
   assign last     = step && (k == LAST);
   assign bit_ofs  = {k, 2'b00};
   // Shifts are formed on the whole captured word so each slice sees its neighbour bit
   assign shr_word = {cil_cap, a_cap[WIDTH-1:1]};
   assign shl_word = {a_cap[WIDTH-2:0], cir_cap};
   assign a_sl     = 4'(a_cap >> bit_ofs);
   assign b_sl     = 4'(b_cap >> bit_ofs);
   assign sum_sl   = {1'b0, a_sl} + {1'b0, b_sl} + {4'd0, carry};

   always_comb begin
      fn_sl = 4'h0;
      case (func_cap)
         3'd0:    fn_sl = sum_sl[3:0];
         3'd1:    fn_sl = a_sl & b_sl;
         3'd2:    fn_sl = a_sl | b_sl;
         3'd3:    fn_sl = a_sl ^ b_sl;
         3'd4:    fn_sl = a_sl;
         3'd5:    fn_sl = b_sl;
         3'd6:    fn_sl = 4'(shr_word >> bit_ofs);
         default: fn_sl = 4'(shl_word >> bit_ofs);
      endcase
      res_sl = com_cap ? ~fn_sl : fn_sl;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         a_cap    <= a;
         b_cap    <= b;
         func_cap <= func;
         com_cap  <= com;
         cil_cap  <= ci_left;
         cir_cap  <= ci_right;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k        <= '0;
         carry    <= 1'b0;
         result   <= '0;
         co_left  <= 1'b0;
         co_right <= 1'b0;
         equ      <= 1'b0;
         zero     <= 1'b0;
         neg_zero <= 1'b0;
         eq_acc   <= 1'b0;
         zero_acc <= 1'b0;
         ones_acc <= 1'b0;
      end else if (accept) begin
         k        <= '0;
         carry    <= ci_right;
         result   <= '0;
         co_left  <= 1'b0;
         co_right <= 1'b0;
         equ      <= 1'b0;
         zero     <= 1'b0;
         neg_zero <= 1'b0;
         eq_acc   <= 1'b1;
         zero_acc <= 1'b1;
         ones_acc <= 1'b1;
      end else if (step) begin
         result   <= (result & ~(SL_MASK << bit_ofs)) | (WIDTH'(res_sl) << bit_ofs);
         carry    <= sum_sl[4];
         k        <= k + KW'(1);
         eq_acc   <= eq_acc & (a_sl == b_sl);
         zero_acc <= zero_acc & (res_sl == 4'h0);
         ones_acc <= ones_acc & (res_sl == 4'hF);
         // Flags are published only once the last slice is known
         if (last) begin
            equ      <= eq_acc & (a_sl == b_sl);
            zero     <= zero_acc & (res_sl == 4'h0);
            neg_zero <= ones_acc & (res_sl == 4'hF);
            co_left  <= (func_cap == 3'd0) ? sum_sl[4] :
                        (func_cap == 3'd7) ? a_cap[WIDTH-1] : 1'b0;
            co_right <= (func_cap == 3'd6) & a_cap[0];
         end
      end
   end
endmodule

// File: tb/tb_xalu_serial.sv
// Bench for xalu_serial: a whole-word reference model checked against WIDTH=16 and
// WIDTH=4 instances under directed and randomized operations.
module tb_xalu_serial;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a, b, result;
   logic [2:0]  func;
   logic        com, ci_left, ci_right, co_left, co_right, equ, zero, neg_zero;

   logic        in_valid4, in_ready4, out_valid4, out_ready4;
   logic [3:0]  a4, b4, result4;
   logic [2:0]  func4;
   logic        com4, ci_left4, ci_right4, co_left4, co_right4, equ4, zero4, neg_zero4;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [15:0] res;
      logic        col, cor, eq, z, nz;
   } exp_t;

   exp_t exp16;
   bit   exp16_vld = 1'b0;

   xalu_serial #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .func(func), .com(com), .ci_left(ci_left), .ci_right(ci_right),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .co_left(co_left), .co_right(co_right), .equ(equ), .zero(zero), .neg_zero(neg_zero)
   );

   xalu_serial #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .func(func4), .com(com4), .ci_left(ci_left4), .ci_right(ci_right4),
      .out_valid(out_valid4), .out_ready(out_ready4), .result(result4),
      .co_left(co_left4), .co_right(co_right4), .equ(equ4), .zero(zero4), .neg_zero(neg_zero4)
   );

   function automatic exp_t model(input int w, input logic [2:0] f, input logic [15:0] av,
                                  input logic [15:0] bv, input logic c, input logic cl,
                                  input logic cr);
      int unsigned m, x, y, r;
      exp_t e;
      m = (32'd1 << w) - 32'd1;
      x = 32'(av) & m;
      y = 32'(bv) & m;
      e = '0;
      r = 0;
      case (f)
         3'd0: begin
            r = x + y + 32'(cr);
            e.col = ((r >> w) & 32'd1) != 0;
         end
         3'd1: r = x & y;
         3'd2: r = x | y;
         3'd3: r = x ^ y;
         3'd4: r = x;
         3'd5: r = y;
         3'd6: begin
            r = (32'(cl) << (w - 1)) | (x >> 1);
            e.cor = x[0];
         end
         default: begin
            r = (x << 1) | 32'(cr);
            e.col = ((x >> (w - 1)) & 32'd1) != 0;
         end
      endcase
      r = r & m;
      if (c) r = ~r & m;
      e.res = 16'(r);
      e.z   = (r == 0);
      e.nz  = (r == m);
      e.eq  = (x == y);
      return e;
   endfunction

   task automatic check_b(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, req);
      end
   endtask

   task automatic check_w(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, req);
      end
   endtask

   task automatic check_i(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Compare process: every cycle the 16-bit result is presented it must match the model
   always @(negedge clk) begin
      if (rst_n && out_valid && exp16_vld) begin
         check_w("res16", result, exp16.res);
         check_b("co_left16", co_left, exp16.col);
         check_b("co_right16", co_right, exp16.cor);
         check_b("equ16", equ, exp16.eq);
         check_b("zero16", zero, exp16.z);
         check_b("neg_zero16", neg_zero, exp16.nz);
         check_b("in_ready_done16", in_ready, 1'b0);
      end
   end

   task automatic scramble16();
      a        = 16'($urandom);
      b        = 16'($urandom);
      func     = 3'($urandom);
      com      = 1'($urandom);
      ci_left  = 1'($urandom);
      ci_right = 1'($urandom);
   endtask

   task automatic op16(input logic [2:0] f, input logic [15:0] av, input logic [15:0] bv,
                       input logic c, input logic cl, input logic cr, input int hold,
                       input bit pulse, output exp_t got);
      int lat;
      logic [15:0] snap;
      @(negedge clk);
      check_b("in_ready_idle16", in_ready, 1'b1);
      func = f; a = av; b = bv; com = c; ci_left = cl; ci_right = cr; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      scramble16();
      exp16     = model(16, f, av, bv, c, cl, cr);
      exp16_vld = 1'b1;
      check_b("in_ready_run16", in_ready, 1'b0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_i("latency16", lat, 4);
      got  = {result, co_left, co_right, equ, zero, neg_zero};
      snap = result;
      for (int i = 0; i < hold; i++) begin
         if (pulse && i == 3) begin
            a = 16'h5555; b = 16'h5555; func = 3'd0; in_valid = 1'b1;
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
      if (hold > 0) begin
         check_w("hold_result16", result, snap);
         check_b("hold_valid16", out_valid, 1'b1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_b("release_valid16", out_valid, 1'b0);
      check_b("release_ready16", in_ready, 1'b1);
   endtask

   task automatic op4(input logic [2:0] f, input logic [3:0] av, input logic [3:0] bv,
                      input logic c, input logic cl, input logic cr, output exp_t got);
      int lat;
      exp_t e;
      @(negedge clk);
      check_b("in_ready_idle4", in_ready4, 1'b1);
      func4 = f; a4 = av; b4 = bv; com4 = c; ci_left4 = cl; ci_right4 = cr; in_valid4 = 1'b1;
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); func4 = 3'($urandom); com4 = 1'($urandom);
      lat = 0;
      while (!out_valid4 && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_i("latency4", lat, 1);
      e = model(4, f, 16'(av), 16'(bv), c, cl, cr);
      @(negedge clk);
      got = {12'h000, result4, co_left4, co_right4, equ4, zero4, neg_zero4};
      check_w("res4", 16'(result4), e.res);
      check_b("co_left4", co_left4, e.col);
      check_b("co_right4", co_right4, e.cor);
      check_b("equ4", equ4, e.eq);
      check_b("zero4", zero4, e.z);
      check_b("neg_zero4", neg_zero4, e.nz);
      out_ready4 = 1'b1;
      @(posedge clk);
      #1;
      out_ready4 = 1'b0;
      check_b("release_valid4", out_valid4, 1'b0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      exp_t got;
      logic [15:0] ra, rb;
      int mode;

      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; func = '0;
      com = 1'b0; ci_left = 1'b0; ci_right = 1'b0;
      in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; func4 = '0;
      com4 = 1'b0; ci_left4 = 1'b0; ci_right4 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_w("reset_result", result, 16'h0000);
      check_b("reset_out_valid", out_valid, 1'b0);
      check_b("reset_in_ready", in_ready, 1'b1);
      check_b("reset_zero", zero, 1'b0);
      check_b("reset_neg_zero", neg_zero, 1'b0);
      check_b("reset_co_left", co_left, 1'b0);
      rst_n = 1'b1;

      // Pin the model and DUT to hand-worked values
      op16(3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 1'b0, got);
      check_w("add_lit_res", got.res, 16'h0000);
      check_b("add_lit_col", got.col, 1'b1);
      check_b("add_lit_zero", got.z, 1'b1);
      check_b("add_lit_equ", got.eq, 1'b0);

      op16(3'd6, 16'h8001, 16'h0000, 1'b0, 1'b1, 1'b0, 1, 1'b0, got);
      check_w("shr_lit_res", got.res, 16'hC000);
      check_b("shr_lit_cor", got.cor, 1'b1);
      check_b("shr_lit_col", got.col, 1'b0);

      op16(3'd7, 16'h8001, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 1'b0, got);
      check_w("shl_lit_res", got.res, 16'h0003);
      check_b("shl_lit_col", got.col, 1'b1);

      op16(3'd3, 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 0, 1'b0, got);
      check_w("xor_lit_res", got.res, 16'hFFFF);
      check_b("xor_lit_nz", got.nz, 1'b1);
      check_b("xor_lit_zero", got.z, 1'b0);
      check_b("xor_lit_equ", got.eq, 1'b1);

      op16(3'd2, 16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 1'b0, 10, 1'b1, got);
      check_w("bp_lit_res", got.res, 16'hAFAF);

      for (int n = 0; n < 40; n++) begin
         mode = $urandom_range(0, 3);
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (mode == 1) rb = ra;
         if (mode == 2) ra = 16'hFFFF;
         if (mode == 3) rb = ~ra;
         op16(3'($urandom), ra, rb, 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 3), 1'b0, got);
      end

      // Abort mid-operation with an asynchronous reset
      @(negedge clk);
      a = 16'h1357; b = 16'h2468; func = 3'd0; com = 1'b0; ci_right = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      exp16_vld = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_w("abort_result", result, 16'h0000);
      check_b("abort_out_valid", out_valid, 1'b0);
      check_b("abort_in_ready", in_ready, 1'b1);
      check_b("abort_co_left", co_left, 1'b0);
      check_b("abort_equ", equ, 1'b0);
      check_b("abort_zero", zero, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_b("post_reset_in_ready", in_ready, 1'b1);
      op16(3'd0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 1'b0, got);
      check_w("post_reset_add", got.res, 16'h0100);

      op4(3'd0, 4'h9, 4'h8, 1'b0, 1'b0, 1'b1, got);
      check_w("w4_lit_res", got.res, 16'h0002);
      check_b("w4_lit_col", got.col, 1'b1);
      for (int n = 0; n < 20; n++) begin
         op4(3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), got);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
